shifter_sll_seq: RTL and testbench

//  Sequential logical left shifter (SLL), the left-direction counterpart of the ALU's

---
 rtl/shifter_sll_seq.sv | 105 ++++++++++
 tb/tb_shifter_sll_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/shifter_sll_seq.sv
// Multi-cycle logical left shifter with start/busy/done handshake, STEP bits per cycle.
// Define SHIFTER_SRL_EN to also accept the logical-right funct code on the same engine.
module shifter_sll_seq #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t      state;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic        right_op;

  logic        start_supported;
  logic        start_right;
  logic [4:0]  step_amt;
  logic [31:0] acc_next;
  logic [4:0]  cnt_next;
  logic        unused_hi;

  // Only the low five bits of the amount matter; the rest is intentionally dropped.
  assign unused_hi = ^dataB[31:5];

  always_comb begin
    start_supported = (Signal == FN_SLL);
    start_right     = 1'b0;
`ifdef SHIFTER_SRL_EN
    if (Signal == FN_SRL) begin
      start_supported = 1'b1;
      start_right     = 1'b1;
    end
`endif
  end

  // The final step may be shorter than STEP so the total never overshoots the amount.
  always_comb begin
    step_amt = (cnt < STEP_AMT) ? cnt : STEP_AMT;
    acc_next = right_op ? (acc >> step_amt) : (acc << step_amt);
    cnt_next = cnt - step_amt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      right_op <= 1'b0;
      dataOut  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc      <= dataA;
            cnt      <= dataB[4:0];
            right_op <= start_right;
            if (dataB[4:0] == 5'd0 || !start_supported) begin
              state   <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              dataOut <= start_supported ? dataA : 32'h0;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt_next;
          if (cnt_next == 5'd0) begin
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            dataOut <= acc_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_sll_seq.sv
// Randomized bench for shifter_sll_seq: STEP=1 and STEP=4 instances share inputs and are
// compared cycle by cycle against a plain-arithmetic model of result and latency.
module tb_shifter_sll_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  sig;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [31:0] out1, out4;
  logic        busy1, busy4, done1, done4;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] prev1, prev4;

  always #5 clk = ~clk;

  shifter_sll_seq #(.STEP(1)) u_step1 (
    .clk(clk), .reset(reset), .start(start), .Signal(sig),
    .dataA(data_a), .dataB(data_b), .dataOut(out1), .busy(busy1), .done(done1)
  );

  shifter_sll_seq #(.STEP(4)) u_step4 (
    .clk(clk), .reset(reset), .start(start), .Signal(sig),
    .dataA(data_a), .dataB(data_b), .dataOut(out4), .busy(busy4), .done(done4)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit supported(input logic [5:0] s);
`ifdef SHIFTER_SRL_EN
    return (s == 6'd0) || (s == 6'd2);
`else
    return (s == 6'd0);
`endif
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [5:0] s);
    int n = int'(b % 32);
    if (s == 6'd0) return a << n;
`ifdef SHIFTER_SRL_EN
    if (s == 6'd2) return a >> n;
`endif
    return 32'h0;
  endfunction

  function automatic int model_latency(input logic [31:0] b, input logic [5:0] s, input int step);
    int n = int'(b % 32);
    if (!supported(s) || n == 0) return 1;
    return 1 + (n + step - 1) / step;
  endfunction

  // Called at a negedge; issues one request and checks every cycle until both results land.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [5:0] s, input bit garble);
    logic [31:0] exp;
    int l1, l4, last;
    exp  = model_result(a, b, s);
    l1   = model_latency(b, s, 1);
    l4   = model_latency(b, s, 4);
    last = (l1 > l4) ? l1 : l4;
    start  = 1'b1;
    data_a = a;
    data_b = b;
    sig    = s;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= last; c++) begin
      check_output($sformatf("s1 busy c%0d", c), {31'b0, busy1}, {31'b0, c < l1});
      check_output($sformatf("s1 done c%0d", c), {31'b0, done1}, {31'b0, c == l1});
      check_output($sformatf("s1 data c%0d", c), out1, (c >= l1) ? exp : prev1);
      check_output($sformatf("s4 busy c%0d", c), {31'b0, busy4}, {31'b0, c < l4});
      check_output($sformatf("s4 done c%0d", c), {31'b0, done4}, {31'b0, c == l4});
      check_output($sformatf("s4 data c%0d", c), out4, (c >= l4) ? exp : prev4);
      if (garble) begin
        data_a = $urandom;
        data_b = $urandom;
        sig    = 6'($urandom);
      end
      start = (c < l1 && c < l4) ? 1'($urandom) : 1'b0;
      if (c < last) @(negedge clk);
    end
    prev1 = exp;
    prev4 = exp;
  endtask

  function automatic logic [5:0] pick_sig();
    int r = int'($urandom_range(0, 3));
    if (r < 2) return 6'd0;
    if (r == 2) return 6'd2;
    return 6'($urandom);
  endfunction

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    sig    = 6'd0;
    data_a = 32'h0;
    data_b = 32'h0;
    prev1  = 32'h0;
    prev4  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst data1", out1, 32'h0);
    check_output("rst busy1", {31'b0, busy1}, 32'h0);
    check_output("rst done1", {31'b0, done1}, 32'h0);
    check_output("rst data4", out4, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check_output("idle busy4", {31'b0, busy4}, 32'h0);
    check_output("idle done4", {31'b0, done4}, 32'h0);

    apply_stimulus(32'h0000_0001, 32'd31,         6'd0, 1'b1);
    @(negedge clk);
    apply_stimulus(32'hDEAD_BEEF, 32'd0,          6'd0, 1'b0);
    @(negedge clk);
    apply_stimulus(32'h8000_0001, 32'h0000_0021,  6'd0, 1'b1);
    @(negedge clk);
    apply_stimulus(32'h0000_00FF, 32'd6,          6'd0, 1'b1);
    @(negedge clk);
    apply_stimulus(32'h8000_0000, 32'd4,          6'd2, 1'b1);
    @(negedge clk);
    apply_stimulus(32'h1234_5678, 32'd1,          6'd0, 1'b0);
    apply_stimulus(32'hA5A5_A5A5, 32'd3,          6'd0, 1'b0);
    apply_stimulus(32'h0F0F_0F0F, 32'd0,          6'd0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      apply_stimulus($urandom, $urandom, pick_sig(), 1'b1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    // Abort a long shift with reset and make sure nothing completes afterwards.
    @(negedge clk);
    start  = 1'b1;
    data_a = 32'hFFFF_FFFF;
    data_b = 32'd31;
    sig    = 6'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("mid busy1", {31'b0, busy1}, 32'h1);
    reset = 1'b0;
    #2;
    check_output("abort data1", out1, 32'h0);
    check_output("abort busy1", {31'b0, busy1}, 32'h0);
    check_output("abort data4", out4, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_output($sformatf("post done1 c%0d", c), {31'b0, done1}, 32'h0);
      check_output($sformatf("post done4 c%0d", c), {31'b0, done4}, 32'h0);
      check_output($sformatf("post data1 c%0d", c), out1, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
